// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM pipeline stage.
//   - state_t       : access sequencer states (IDLE/BUS/DONE/ABORT)
//   - SZ_*          : access size codes carried on xm_size
//   - isMisaligned  : alignment check shared by the stage and any future
//                     store buffer
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUS   = 2'b01,
        ST_DONE  = 2'b10,
        ST_ABORT = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 2'b11 is handled as a word everywhere.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            default: bad = (addrLo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: word-wide data-bus request/ready handshake.
//   req   : access request, held until ready or abort (master -> slave)
//   we    : 1 = store
//   addr  : word-aligned byte address
//   be    : byte enables
//   wdata : lane-replicated store data
//   ready : access completion (slave -> master)
//   rdata : read word, valid with ready
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output be, output wdata,
                    input ready, input rdata);
    modport slave  (input req, input we, input addr, input be, input wdata,
                    output ready, output rdata);
endinterface

// File: rtl/mem_access_align.sv
// mem_align: purely combinational lane handling for sub-word accesses.
//   size/isUnsigned/addrLo : access shape
//   rdata    -> loadData   : selected lane, zero/sign extended to 32 bits
//   wdata    -> storeData  : store value replicated across all lanes
//               storeBe    : byte enables for the addressed lane(s)
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [1:0]  addrLo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] storeData,
    output logic [3:0]  storeBe
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Pick the byte and halfword lanes addressed by the low address bits.
    always_comb begin
        byteLane = 8'h00;
        case (addrLo)
            2'b00:   byteLane = rdata[7:0];
            2'b01:   byteLane = rdata[15:8];
            2'b10:   byteLane = rdata[23:16];
            2'b11:   byteLane = rdata[31:24];
            default: byteLane = 8'h00;
        endcase
        if (addrLo[1]) begin
            halfLane = rdata[31:16];
        end else begin
            halfLane = rdata[15:0];
        end
    end

    // Extend loads and shape stores according to the access size.
    always_comb begin
        loadData  = 32'h0000_0000;
        storeData = 32'h0000_0000;
        storeBe   = 4'b0000;
        case (size)
            SZ_BYTE: begin
                if (isUnsigned) begin
                    loadData = {24'h00_0000, byteLane};
                end else begin
                    loadData = {{24{byteLane[7]}}, byteLane};
                end
                storeData = {4{wdata[7:0]}};
                storeBe   = 4'b0001 << addrLo;
            end
            SZ_HALF: begin
                if (isUnsigned) begin
                    loadData = {16'h0000, halfLane};
                end else begin
                    loadData = {{16{halfLane[15]}}, halfLane};
                end
                storeData = {2{wdata[15:0]}};
                if (addrLo[1]) begin
                    storeBe = 4'b1100;
                end else begin
                    storeBe = 4'b0011;
                end
            end
            default: begin
                loadData  = rdata;
                storeData = wdata;
                storeBe   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs loads/stores over the dbus handshake,
// stalls upstream while an access is in flight, and feeds the MEM/WB register.
//   clk, rst            : clock, asynchronous active-high reset
//   xm_*                : EX/MEM instruction fields (held stable while stalled)
//   dbus                : data-bus master port (req/we/addr/be/wdata, ready/rdata)
//   me_*                : values latched by MEM/WB
//   mem_stall           : freeze PC/IF/ID/EX/EX-MEM
//   misalign            : misaligned access flagged in the instruction's cycle
//   bus_err             : one-cycle pulse when an access times out
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xm_memRead,
    input  logic        xm_memWrite,
    input  logic [1:0]  xm_size,
    input  logic        xm_unsigned,
    input  logic [31:0] xm_addr,
    input  logic [31:0] xm_wdata,
    input  logic        xm_writeReg,
    input  logic        xm_aluOut_WB_memOut,
    input  logic [4:0]  xm_rd,
    mem_access_if.master dbus,
    output logic        me_aluOut_WB_memOut,
    output logic        me_writeReg,
    output logic [31:0] me_outMem,
    output logic [31:0] me_outAlu,
    output logic [4:0]  me_rd,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [9:0]  toCnt;
    logic [31:0] rdata_q;

    logic        acc;
    logic        isStore;
    logic        badAlign;
    logic [31:0] loadData;
    logic [31:0] storeData;
    logic [3:0]  storeBe;

    // A store wins when both read and write are flagged.
    assign acc      = xm_memRead | xm_memWrite;
    assign isStore  = xm_memWrite;
    assign badAlign = isMisaligned(xm_size, xm_addr[1:0]);

    mem_align u_align (
        .size       (xm_size),
        .isUnsigned (xm_unsigned),
        .addrLo     (xm_addr[1:0]),
        .rdata      (dbus.rdata),
        .wdata      (xm_wdata),
        .loadData   (loadData),
        .storeData  (storeData),
        .storeBe    (storeBe)
    );

    assign me_outAlu           = xm_addr;
    assign me_rd               = xm_rd;
    assign me_aluOut_WB_memOut = xm_aluOut_WB_memOut;

    // Stall, bubble insertion and load-result selection for the current state.
    always_comb begin
        mem_stall   = 1'b0;
        misalign    = 1'b0;
        me_writeReg = xm_writeReg;
        me_outMem   = 32'h0000_0000;
        case (state)
            ST_IDLE: begin
                if (acc && !badAlign) begin
                    mem_stall   = 1'b1;
                    me_writeReg = 1'b0;
                end else if (acc) begin
                    misalign    = 1'b1;
                    me_writeReg = 1'b0;
                end else begin
                    me_writeReg = xm_writeReg;
                end
            end
            ST_BUS: begin
                mem_stall   = 1'b1;
                me_writeReg = 1'b0;
            end
            ST_DONE: begin
                me_outMem = rdata_q;
            end
            ST_ABORT: begin
                me_writeReg = 1'b0;
            end
            default: begin
                me_writeReg = 1'b0;
            end
        endcase
    end

    // Access sequencer: launches the bus request, waits for ready or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= 32'h0000_0000;
            dbus.be    <= 4'b0000;
            dbus.wdata <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            toCnt      <= 10'd0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (acc && !badAlign) begin
                        dbus.req  <= 1'b1;
                        dbus.we   <= isStore;
                        dbus.addr <= {xm_addr[31:2], 2'b00};
                        if (isStore) begin
                            dbus.be    <= storeBe;
                            dbus.wdata <= storeData;
                        end else begin
                            dbus.be    <= 4'b1111;
                            dbus.wdata <= 32'h0000_0000;
                        end
                        toCnt <= 10'd0;
                        state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (dbus.ready) begin
                        rdata_q  <= isStore ? 32'h0000_0000 : loadData;
                        dbus.req <= 1'b0;
                        toCnt    <= 10'd0;
                        state    <= ST_DONE;
                    end else if (toCnt == TO_LAST) begin
                        dbus.req <= 1'b0;
                        bus_err  <= 1'b1;
                        toCnt    <= 10'd0;
                        state    <= ST_ABORT;
                    end else begin
                        toCnt <= toCnt + 10'd1;
                    end
                end
                // Return to IDLE unconditionally so the still-held
                // instruction is not relaunched.
                ST_DONE:  state <= ST_IDLE;
                ST_ABORT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        xm_memRead, xm_memWrite, xm_unsigned, xm_writeReg, xm_aluOut_WB_memOut;
    logic [1:0]  xm_size;
    logic [31:0] xm_addr, xm_wdata;
    logic [4:0]  xm_rd;
    logic        me_aluOut_WB_memOut, me_writeReg, mem_stall, misalign, bus_err;
    logic [31:0] me_outMem, me_outAlu;
    logic [4:0]  me_rd;

    mem_access_if dbus();

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .xm_memRead(xm_memRead), .xm_memWrite(xm_memWrite), .xm_size(xm_size),
        .xm_unsigned(xm_unsigned), .xm_addr(xm_addr), .xm_wdata(xm_wdata),
        .xm_writeReg(xm_writeReg), .xm_aluOut_WB_memOut(xm_aluOut_WB_memOut), .xm_rd(xm_rd),
        .dbus(dbus),
        .me_aluOut_WB_memOut(me_aluOut_WB_memOut), .me_writeReg(me_writeReg),
        .me_outMem(me_outMem), .me_outAlu(me_outAlu), .me_rd(me_rd),
        .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] outMem;
        logic        wreg;
        int          stall;
    } exp_t;
    exp_t expQ[$];

    // observations from the last run_access
    int          obsStall, obsReq, obsMis, obsErrCnt;
    logic [31:0] obsAddr, obsWdata, obsOutMem;
    logic [3:0]  obsBe;
    logic        obsWe, obsWreg, obsErrEnd, obsDone, obsReqAfter;

    task automatic drive_xm(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wd, input logic wreg);
        xm_memRead = rd; xm_memWrite = wr; xm_size = sz; xm_unsigned = uns;
        xm_addr = addr; xm_wdata = wd; xm_writeReg = wreg;
        xm_aluOut_WB_memOut = rd; xm_rd = 5'd9;
    endtask

    task automatic drive_idle();
        drive_xm(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Acts as bus agent: asserts ready in BUS cycle readyAt (0 = never).
    // Starts just after a posedge with the instruction already driven and
    // returns just after the posedge that ends the first unstalled cycle.
    task automatic run_access(input int readyAt, input logic [31:0] rdata);
        int busCycle = 0;
        obsStall = 0; obsReq = 0; obsMis = 0; obsErrCnt = 0; obsDone = 1'b0;
        obsAddr = 32'hx; obsBe = 4'hx; obsWdata = 32'hx; obsWe = 1'bx;
        obsOutMem = 32'hx; obsWreg = 1'bx; obsErrEnd = 1'bx; obsReqAfter = 1'bx;
        dbus.rdata = rdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_stall) obsStall++;
            if (misalign) obsMis++;
            if (bus_err) obsErrCnt++;
            if (dbus.req) begin
                obsReq++;
                obsAddr = dbus.addr; obsBe = dbus.be; obsWdata = dbus.wdata; obsWe = dbus.we;
            end
            if (!mem_stall) begin
                obsOutMem = me_outMem; obsWreg = me_writeReg; obsErrEnd = bus_err;
                obsDone = 1'b1;
            end
            @(posedge clk); #1;
            if (obsDone) begin
                obsReqAfter = dbus.req;
                dbus.ready = 1'b0;
                break;
            end
            if (dbus.req) begin
                busCycle++;
                dbus.ready = (busCycle == readyAt);
            end else begin
                dbus.ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (dbus.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dbus.req); end
        checks++; if (dbus.addr !== 32'h0 || dbus.be !== 4'h0 || dbus.wdata !== 32'h0 || dbus.we !== 1'b0) begin
            failures++; $display("FAIL reset_bus got addr=%h be=%b wdata=%h we=%b exp zeros", dbus.addr, dbus.be, dbus.wdata, dbus.we); end
        checks++; if ({mem_stall, misalign, bus_err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {mem_stall, misalign, bus_err}); end
        checks++; if (me_outMem !== 32'h0) begin failures++; $display("FAIL reset_outMem got=%h exp=0", me_outMem); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_alu();
        drive_xm(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h5555_5555, 1'b1);
        dbus.ready = 1'b1;  // stray ready outside BUS must be ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (me_outAlu !== 32'h1234) begin failures++; $display("FAIL alu_outAlu got=%h exp=00001234", me_outAlu); end
            checks++; if (me_writeReg !== 1'b1) begin failures++; $display("FAIL alu_writeReg got=%b exp=1", me_writeReg); end
            checks++; if (mem_stall !== 1'b0 || dbus.req !== 1'b0) begin
                failures++; $display("FAIL alu_nostall got stall=%b req=%b exp 0/0", mem_stall, dbus.req); end
            checks++; if (me_rd !== 5'd9 || me_outMem !== 32'h0) begin
                failures++; $display("FAIL alu_pass got rd=%0d outMem=%h exp 9/0", me_rd, me_outMem); end
            @(posedge clk); #1;
        end
        dbus.ready = 1'b0;
        drive_idle();
    endtask

    task automatic test_byte_load();
        exp_t e;
        expQ.push_back('{32'h100, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1, 2});
        drive_xm(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1'b1);
        run_access(1, 32'h80FF_FF7F);
        e = expQ.pop_front();
        checks++; if (obsStall !== e.stall) begin failures++; $display("FAIL lb_stall got=%0d exp=%0d", obsStall, e.stall); end
        checks++; if (obsAddr !== e.addr || obsBe !== e.be || obsWe !== e.we) begin
            failures++; $display("FAIL lb_bus got addr=%h be=%b we=%b exp addr=%h be=%b we=%b", obsAddr, obsBe, obsWe, e.addr, e.be, e.we); end
        checks++; if (obsOutMem !== e.outMem || obsWreg !== e.wreg) begin
            failures++; $display("FAIL lb_done got outMem=%h wreg=%b exp outMem=%h wreg=%b", obsOutMem, obsWreg, e.outMem, e.wreg); end
        drive_idle();
    endtask

    task automatic test_half_store();
        exp_t e;
        expQ.push_back('{32'h100, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0, 1'b0, 4});
        drive_xm(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 1'b0);
        run_access(3, 32'hFFFF_FFFF);
        e = expQ.pop_front();
        checks++; if (obsStall !== e.stall) begin failures++; $display("FAIL sh_stall got=%0d exp=%0d", obsStall, e.stall); end
        checks++; if (obsReq !== 3) begin failures++; $display("FAIL sh_reqcycles got=%0d exp=3", obsReq); end
        checks++; if (obsAddr !== e.addr || obsBe !== e.be || obsWdata !== e.wdata || obsWe !== e.we) begin
            failures++; $display("FAIL sh_bus got addr=%h be=%b wdata=%h we=%b exp addr=%h be=%b wdata=%h we=%b",
                                 obsAddr, obsBe, obsWdata, obsWe, e.addr, e.be, e.wdata, e.we); end
        drive_idle();
    endtask

    task automatic test_misalign();
        drive_xm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 1'b1);
        run_access(1, 32'h1111_1111);
        checks++; if (obsMis !== 1) begin failures++; $display("FAIL mis_pulse got=%0d exp=1", obsMis); end
        checks++; if (obsWreg !== 1'b0) begin failures++; $display("FAIL mis_writeReg got=%b exp=0", obsWreg); end
        checks++; if (obsStall !== 0 || obsReq !== 0 || obsReqAfter !== 1'b0) begin
            failures++; $display("FAIL mis_nobus got stall=%0d req=%0d reqAfter=%b exp 0/0/0", obsStall, obsReq, obsReqAfter); end
        drive_idle();
        // misaligned half, aligned-byte sanity: half at odd address also flags
        drive_xm(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h0, 1'b0);
        run_access(1, 32'h0);
        checks++; if (obsMis !== 1 || obsReq !== 0) begin
            failures++; $display("FAIL mis_half got mis=%0d req=%0d exp 1/0", obsMis, obsReq); end
        drive_idle();
    endtask

    task automatic test_timeout();
        drive_xm(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        run_access(0, 32'h0);
        checks++; if (obsDone !== 1'b1) begin failures++; $display("FAIL to_done got=%b exp=1", obsDone); end
        checks++; if (obsReq !== TO) begin failures++; $display("FAIL to_reqcycles got=%0d exp=%0d", obsReq, TO); end
        checks++; if (obsErrCnt !== 1 || obsErrEnd !== 1'b1) begin
            failures++; $display("FAIL to_buserr got cnt=%0d inAbort=%b exp 1/1", obsErrCnt, obsErrEnd); end
        checks++; if (obsWreg !== 1'b0 || obsStall !== TO + 1) begin
            failures++; $display("FAIL to_abort got wreg=%b stall=%0d exp 0/%0d", obsWreg, obsStall, TO + 1); end
        drive_idle();
        @(negedge clk);
        checks++; if (bus_err !== 1'b0 || mem_stall !== 1'b0 || dbus.req !== 1'b0) begin
            failures++; $display("FAIL to_idle got err=%b stall=%b req=%b exp 000", bus_err, mem_stall, dbus.req); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_bus();
        exp_t e;
        expQ.push_back('{32'h300, 4'b1111, 32'h0, 1'b0, 32'h0000_A55A, 1'b1, 2});
        drive_xm(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0302, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++; if (dbus.req !== 1'b1) begin failures++; $display("FAIL rb_launch got=%b exp=1", dbus.req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dbus.req !== 1'b0) begin failures++; $display("FAIL rb_asyncdrop got=%b exp=0", dbus.req); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_access(1, 32'hA55A_0000);
        e = expQ.pop_front();
        checks++; if (obsStall !== e.stall || obsAddr !== e.addr) begin
            failures++; $display("FAIL rb_relaunch got stall=%0d addr=%h exp %0d/%h", obsStall, obsAddr, e.stall, e.addr); end
        checks++; if (obsOutMem !== e.outMem || obsWreg !== e.wreg) begin
            failures++; $display("FAIL rb_done got outMem=%h wreg=%b exp %h/%b", obsOutMem, obsWreg, e.outMem, e.wreg); end
        drive_idle();
    endtask

    task automatic test_load_variants();
        logic [1:0]  sz[5]   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
        logic        un[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad[5]   = '{32'h3, 32'h0, 32'h2, 32'h0, 32'h4};
        logic [31:0] res[5]  = '{32'h0000_0080, 32'h0000_007F, 32'h0000_80FF, 32'hFFFF_FF7F, 32'h80FF_FF7F};
        exp_t e;
        for (int i = 0; i < 5; i++)
            expQ.push_back('{ad[i] & 32'hFFFF_FFFC, 4'b1111, 32'h0, 1'b0, res[i], 1'b1, 2});
        for (int i = 0; i < 5; i++) begin
            drive_xm(1'b1, 1'b0, sz[i], un[i], ad[i], 32'h0, 1'b1);
            run_access(1, 32'h80FF_FF7F);
            e = expQ.pop_front();
            checks++; if (obsOutMem !== e.outMem || obsAddr !== e.addr || obsBe !== e.be) begin
                failures++; $display("FAIL ld_var%0d got outMem=%h addr=%h be=%b exp %h/%h/%b", i, obsOutMem, obsAddr, obsBe, e.outMem, e.addr, e.be); end
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic        wr[3]  = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  sz[3]  = '{2'b00, 2'b01, 2'b00};
        logic [31:0] ad[3]  = '{32'h201, 32'h202, 32'h203};
        logic [31:0] wd[3]  = '{32'h0000_00A5, 32'h0, 32'h1234_5678};
        int          rdy[3] = '{2, 1, 1};
        exp_t e;
        expQ.push_back('{32'h200, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0, 3});
        expQ.push_back('{32'h200, 4'b1111, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1, 2});
        expQ.push_back('{32'h200, 4'b1000, 32'h7878_7878, 1'b1, 32'h0, 1'b0, 2});
        for (int i = 0; i < 3; i++) begin
            drive_xm(~wr[i], wr[i], sz[i], 1'b0, ad[i], wd[i], ~wr[i]);
            run_access(rdy[i], 32'h8001_1234);
            e = expQ.pop_front();
            checks++; if (obsStall !== e.stall || obsBe !== e.be || obsWe !== e.we) begin
                failures++; $display("FAIL b2b%0d_ctl got stall=%0d be=%b we=%b exp %0d/%b/%b", i, obsStall, obsBe, obsWe, e.stall, e.be, e.we); end
            checks++; if ((e.we && obsWdata !== e.wdata) || obsOutMem !== e.outMem || obsWreg !== e.wreg) begin
                failures++; $display("FAIL b2b%0d_data got wdata=%h outMem=%h wreg=%b exp %h/%h/%b", i, obsWdata, obsOutMem, obsWreg, e.wdata, e.outMem, e.wreg); end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        dbus.ready = 1'b0;
        dbus.rdata = 32'h0;
        drive_idle();
        test_reset();
        test_alu();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_timeout();
        test_reset_in_bus();
        test_load_variants();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
